// File: rtl/aes_cmd_framer.sv
// Byte-serial command framer for the AES core: parses a 4-byte header, holds the
// header fields stable for the core, and streams the payload through a small FIFO.
module aes_cmd_framer #(
  parameter int PAYLOAD_BYTES = 16,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [1:0]  hdr_opcode,
  output logic [1:0]  hdr_source_id,
  output logic [1:0]  hdr_dest_id,
  output logic        hdr_encdec,
  output logic [23:0] hdr_addr,
  output logic        hdr_valid,
  output logic [7:0]  data_out,
  output logic        valid_out,
  input  logic        ready_out,
  output logic        frame_done,
  output logic        drop
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(FIFO_DEPTH);
  localparam logic [7:0]  LAST_C  = 8'(PAYLOAD_BYTES);

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_PAYLOAD, S_DRAIN} state_t;

  state_t        state;
  logic [1:0]    hdr_cnt;
  logic [7:0]    pay_cnt;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic [PW:0]   count_next;
  logic          push;
  logic          pop;

  always_comb begin
    case (state)
      S_IDLE, S_HDR: in_ready = 1'b1;
      S_PAYLOAD:     in_ready = (count < DEPTH_C);
      default:       in_ready = 1'b0;
    endcase
  end

  assign push       = in_valid && in_ready && (state == S_PAYLOAD);
  assign pop        = valid_out && ready_out;
  assign count_next = count + (PW+1)'(push) - (PW+1)'(pop);
  assign valid_out  = (count != '0);
  assign data_out   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      hdr_cnt       <= '0;
      pay_cnt       <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      hdr_opcode    <= '0;
      hdr_source_id <= '0;
      hdr_dest_id   <= '0;
      hdr_encdec    <= 1'b0;
      hdr_addr      <= '0;
      hdr_valid     <= 1'b0;
      frame_done    <= 1'b0;
      drop          <= 1'b0;
      // Entries are cleared so data_out reads 0 straight out of reset.
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      frame_done <= 1'b0;
      drop       <= 1'b0;
      count      <= count_next;
      if (push) begin
        mem[wr_ptr] <= in_data;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);

      case (state)
        S_IDLE: begin
          if (in_valid) begin
            if (in_data[7]) begin
              hdr_encdec    <= in_data[6];
              hdr_dest_id   <= in_data[5:4];
              hdr_source_id <= in_data[3:2];
              hdr_opcode    <= in_data[1:0];
              hdr_cnt       <= '0;
              state         <= S_HDR;
            end else begin
              drop <= 1'b1;
            end
          end
        end
        S_HDR: begin
          if (in_valid) begin
            hdr_addr <= {hdr_addr[15:0], in_data};
            hdr_cnt  <= hdr_cnt + 2'd1;
            if (hdr_cnt == 2'd2) begin
              hdr_cnt   <= '0;
              pay_cnt   <= '0;
              hdr_valid <= 1'b1;
              state     <= S_PAYLOAD;
            end
          end
        end
        S_PAYLOAD: begin
          if (push) begin
            pay_cnt <= pay_cnt + 8'd1;
            if (pay_cnt + 8'd1 == LAST_C) state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          // Also covers entering DRAIN with an already-empty FIFO.
          if (count_next == '0) begin
            state      <= S_IDLE;
            hdr_valid  <= 1'b0;
            frame_done <= 1'b1;
            pay_cnt    <= '0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_cmd_framer.sv
// Bench for aes_cmd_framer: randomized frames against a byte-level frame model,
// plus directed frames on a PAYLOAD_BYTES=1 / FIFO_DEPTH=2 instance.
module tb_aes_cmd_framer;

  localparam int P = 16;
  localparam int D = 4;
  localparam int PH_IDLE = 0, PH_HDR = 1, PH_PAY = 2, PH_DRAIN = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  hdr_opcode, hdr_source_id, hdr_dest_id;
  logic        hdr_encdec;
  logic [23:0] hdr_addr;
  logic        hdr_valid;
  logic [7:0]  data_out;
  logic        valid_out;
  logic        ready_out = 1'b0;
  logic        frame_done;
  logic        drop;

  logic [7:0]  s_in_data = '0;
  logic        s_in_valid = 1'b0;
  logic        s_in_ready;
  logic [1:0]  s_opcode, s_source_id, s_dest_id;
  logic        s_encdec;
  logic [23:0] s_addr;
  logic        s_hdr_valid;
  logic [7:0]  s_data_out;
  logic        s_valid_out;
  logic        s_ready_out = 1'b1;
  logic        s_frame_done;
  logic        s_drop;

  always #5 clk = ~clk;

  aes_cmd_framer #(.PAYLOAD_BYTES(P), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .hdr_opcode(hdr_opcode), .hdr_source_id(hdr_source_id), .hdr_dest_id(hdr_dest_id),
    .hdr_encdec(hdr_encdec), .hdr_addr(hdr_addr), .hdr_valid(hdr_valid),
    .data_out(data_out), .valid_out(valid_out), .ready_out(ready_out),
    .frame_done(frame_done), .drop(drop)
  );

  aes_cmd_framer #(.PAYLOAD_BYTES(1), .FIFO_DEPTH(2)) dut_small (
    .clk(clk), .rst(rst), .in_data(s_in_data), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .hdr_opcode(s_opcode), .hdr_source_id(s_source_id), .hdr_dest_id(s_dest_id),
    .hdr_encdec(s_encdec), .hdr_addr(s_addr), .hdr_valid(s_hdr_valid),
    .data_out(s_data_out), .valid_out(s_valid_out), .ready_out(s_ready_out),
    .frame_done(s_frame_done), .drop(s_drop)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out waiting at %0t", name, $time);
  endtask

  // Frame model: phase, buffered payload, header as the core should see it.
  int         ph = PH_IDLE;
  int         m_hcnt = 0;
  int         m_pcount = 0;
  logic [7:0] hb [4];
  logic [7:0] q [$];
  logic       m_hv = 1'b0, m_done = 1'b0, m_drop = 1'b0;
  logic [1:0] m_op = '0, m_src = '0, m_dst = '0;
  logic       m_ed = 1'b0;
  logic [23:0] m_addr = '0;
  logic       m_acc = 1'b0;
  logic       e_acc, e_pop;
  int         ph0;

  // Monitor results.
  logic [7:0] got [$];
  int         n_done = 0, n_drop = 0;
  logic [1:0] cap_op, cap_src, cap_dst;
  logic       cap_ed;
  logic [23:0] cap_addr;

  function automatic logic exp_in_ready();
    if (ph == PH_PAY) return (q.size() < D);
    return (ph != PH_DRAIN);
  endfunction

  always @(posedge clk) begin
    if (!rst && valid_out && ready_out) got.push_back(data_out);
    if (frame_done) n_done++;
    if (drop) n_drop++;
    if (hdr_valid) begin
      cap_op = hdr_opcode; cap_src = hdr_source_id; cap_dst = hdr_dest_id;
      cap_ed = hdr_encdec; cap_addr = hdr_addr;
    end
    if (rst) begin
      ph = PH_IDLE; q.delete(); m_hv = 0; m_done = 0; m_drop = 0; m_pcount = 0; m_hcnt = 0;
      m_op = 0; m_src = 0; m_dst = 0; m_ed = 0; m_addr = 0; m_acc = 0;
    end else begin
      m_acc  = in_valid && in_ready;
      e_acc  = in_valid && exp_in_ready();
      e_pop  = ready_out && (q.size() != 0);
      ph0    = ph;
      m_done = 0;
      m_drop = 0;
      if (e_pop) void'(q.pop_front());
      if (e_acc) begin
        case (ph0)
          PH_IDLE: begin
            if (in_data[7]) begin hb[0] = in_data; m_hcnt = 1; ph = PH_HDR; end
            else m_drop = 1;
          end
          PH_HDR: begin
            hb[m_hcnt] = in_data;
            m_hcnt++;
            if (m_hcnt == 4) begin
              ph = PH_PAY; m_hv = 1; m_pcount = 0;
              m_ed = hb[0][6]; m_dst = hb[0][5:4]; m_src = hb[0][3:2]; m_op = hb[0][1:0];
              m_addr = {hb[1], hb[2], hb[3]};
            end
          end
          PH_PAY: begin
            q.push_back(in_data);
            m_pcount++;
            if (m_pcount == P) ph = PH_DRAIN;
          end
          default: ;
        endcase
      end
      if (ph0 == PH_DRAIN && q.size() == 0) begin
        ph = PH_IDLE; m_hv = 0; m_done = 1;
      end
    end
  end

  logic chk_en = 1'b0;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", in_ready, exp_in_ready());
      chk("hdr_valid", hdr_valid, m_hv);
      if (m_hv) begin
        chk("hdr_opcode", hdr_opcode, m_op);
        chk("hdr_source_id", hdr_source_id, m_src);
        chk("hdr_dest_id", hdr_dest_id, m_dst);
        chk("hdr_encdec", hdr_encdec, m_ed);
        chk("hdr_addr", hdr_addr, m_addr);
      end
      chk("valid_out", valid_out, q.size() != 0);
      if (q.size() != 0) chk("data_out", data_out, q[0]);
      chk("frame_done", frame_done, m_done);
      chk("drop", drop, m_drop);
    end
  end

  // Stimulus for the main instance.
  logic [7:0] tx [$];
  logic       rst_req = 1'b1;
  int         vdty = 100, rdty = 100;

  task automatic step();
    @(negedge clk);
    rst = rst_req;
    if (!rst_req && tx.size() != 0 && $urandom_range(99) < vdty) begin
      in_valid = 1'b1; in_data = tx[0];
    end else begin
      in_valid = 1'b0; in_data = 8'($urandom);
    end
    ready_out = ($urandom_range(99) < rdty);
    @(posedge clk);
    #1;
    if (m_acc) void'(tx.pop_front());
  endtask

  task automatic run_until_idle(input int bound, input string name);
    int c = 0;
    while (!(tx.size() == 0 && ph == PH_IDLE && q.size() == 0) && c < bound) begin
      step();
      c++;
    end
    if (c >= bound) timeout(name);
    step();
    step();
  endtask

  task automatic add_frame(input logic [7:0] b0, input logic [23:0] a, input int seed_kind);
    tx.push_back(b0);
    tx.push_back(a[23:16]);
    tx.push_back(a[15:8]);
    tx.push_back(a[7:0]);
    for (int i = 0; i < P; i++) tx.push_back(seed_kind == 0 ? 8'(i) : 8'($urandom));
  endtask

  task automatic chk_got_seq(input string name);
    chk({name, "_len"}, got.size(), P);
    for (int i = 0; i < P && i < got.size(); i++) chk({name, "_byte"}, got[i], 8'(i));
  endtask

  task automatic s_send(input logic [7:0] b);
    logic taken = 1'b0;
    for (int c = 0; c < 50 && !taken; c++) begin
      @(negedge clk);
      s_in_valid = 1'b1;
      s_in_data  = b;
      taken      = s_in_ready;
      @(posedge clk);
    end
    #1 s_in_valid = 1'b0;
    if (!taken) timeout("small_send");
  endtask

  task automatic small_frame(input logic [7:0] b0, input logic [23:0] a, input logic [7:0] p);
    int dn = 0, pops = 0;
    s_send(b0);
    s_send(a[23:16]);
    s_send(a[15:8]);
    s_send(a[7:0]);
    s_send(p);
    for (int c = 0; c < 20 && dn == 0; c++) begin
      @(negedge clk);
      if (s_valid_out) begin
        pops++;
        chk("small_hv", s_hdr_valid, 1);
        chk("small_opcode", s_opcode, b0[1:0]);
        chk("small_source_id", s_source_id, b0[3:2]);
        chk("small_dest_id", s_dest_id, b0[5:4]);
        chk("small_encdec", s_encdec, b0[6]);
        chk("small_addr", s_addr, a);
        chk("small_data", s_data_out, p);
      end
      if (s_frame_done) begin
        dn++;
        chk("small_hv_low", s_hdr_valid, 0);
      end
    end
    chk("small_done", dn, 1);
    chk("small_pops", pops, 1);
  endtask

  initial begin
    int d0, r0;
    logic [7:0] exp_all [$];
    logic [7:0] b0;
    logic [23:0] a;

    // Reset and reset values.
    step();
    chk_en = 1'b1;
    step();
    chk("rst_hdr_opcode", hdr_opcode, 0);
    chk("rst_hdr_source_id", hdr_source_id, 0);
    chk("rst_hdr_dest_id", hdr_dest_id, 0);
    chk("rst_hdr_encdec", hdr_encdec, 0);
    chk("rst_hdr_addr", hdr_addr, 0);
    chk("rst_hdr_valid", hdr_valid, 0);
    chk("rst_valid_out", valid_out, 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_drop", drop, 0);
    rst_req = 1'b0;
    step();
    chk("rst_in_ready", in_ready, 1);

    // Basic frame.
    vdty = 100; rdty = 100; got.delete(); d0 = n_done;
    add_frame(8'hC7, 24'h123456, 0);
    run_until_idle(200, "basic");
    chk("basic_opcode", cap_op, 3);
    chk("basic_source_id", cap_src, 1);
    chk("basic_dest_id", cap_dst, 0);
    chk("basic_encdec", cap_ed, 1);
    chk("basic_addr", cap_addr, 24'h123456);
    chk_got_seq("basic");
    chk("basic_done_count", n_done - d0, 1);
    chk("basic_hv_after", hdr_valid, 0);

    // Backpressure.
    rdty = 0; got.delete(); d0 = n_done;
    add_frame(8'hA5, 24'hABCDEF, 0);
    for (int i = 0; i < 30; i++) step();
    chk("bp_in_ready", in_ready, 0);
    chk("bp_valid_out", valid_out, 1);
    chk("bp_data_out", data_out, 8'h00);
    chk("bp_left", tx.size(), P - D);
    chk("bp_no_pops", got.size(), 0);
    for (int i = 0; i < 10; i++) step();
    chk("bp_data_hold", data_out, 8'h00);
    rdty = 100;
    run_until_idle(200, "bp");
    chk_got_seq("bp");
    chk("bp_done_count", n_done - d0, 1);

    // Junk rejection.
    got.delete(); d0 = n_done; r0 = n_drop;
    tx.push_back(8'h05);
    tx.push_back(8'h7F);
    add_frame(8'h9B, 24'h00F00D, 0);
    run_until_idle(200, "junk");
    chk("junk_drops", n_drop - r0, 2);
    chk("junk_done_count", n_done - d0, 1);
    chk("junk_opcode", cap_op, 3);
    chk("junk_source_id", cap_src, 2);
    chk("junk_dest_id", cap_dst, 1);
    chk("junk_addr", cap_addr, 24'h00F00D);
    chk_got_seq("junk");

    // Mid-payload reset after 7 payload bytes.
    d0 = n_done;
    add_frame(8'hE1, 24'h555555, 0);
    begin
      int c = 0;
      while (!(ph == PH_PAY && m_pcount == 7) && c < 200) begin step(); c++; end
      if (c >= 200) timeout("mid_rst_wait");
    end
    rst_req = 1'b1;
    tx.delete();
    step();
    rst_req = 1'b0;
    chk("mr_valid_out", valid_out, 0);
    chk("mr_hdr_valid", hdr_valid, 0);
    chk("mr_in_ready", in_ready, 1);
    step();
    step();
    chk("mr_no_done", n_done - d0, 0);
    got.delete();
    add_frame(8'hC7, 24'h123456, 0);
    run_until_idle(200, "after_rst");
    chk_got_seq("after_rst");
    chk("after_rst_addr", cap_addr, 24'h123456);
    chk("after_rst_done", n_done - d0, 1);

    // Randomized back-to-back frames with gaps and junk.
    vdty = 50; rdty = 50; got.delete(); d0 = n_done;
    for (int f = 0; f < 20; f++) begin
      if ($urandom_range(3) == 0) tx.push_back({1'b0, 7'($urandom)});
      b0 = {1'b1, 7'($urandom)};
      a  = 24'($urandom);
      tx.push_back(b0);
      tx.push_back(a[23:16]);
      tx.push_back(a[15:8]);
      tx.push_back(a[7:0]);
      for (int i = 0; i < P; i++) begin
        logic [7:0] pb;
        pb = 8'($urandom);
        tx.push_back(pb);
        exp_all.push_back(pb);
      end
    end
    run_until_idle(20000, "random");
    chk("rand_len", got.size(), exp_all.size());
    for (int i = 0; i < exp_all.size() && i < got.size(); i++) chk("rand_byte", got[i], exp_all[i]);
    chk("rand_done_count", n_done - d0, 20);

    // Single-byte frames on the small instance.
    in_valid = 1'b0;
    small_frame(8'hC7, 24'h123456, 8'h3C);
    for (int f = 0; f < 4; f++) small_frame({1'b1, 7'($urandom)}, 24'($urandom), 8'($urandom));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
